signal_delay_ctrl: RTL and testbench

Sequencer that sits in front of the existing signal_delayer and owns its delay_value and sig_in ports. Accepts delay reconfiguration requests over a valid/ready handshake. Before a new delay is applied, it drains the delay line by forcing the delayer input low, so no partially delayed pulse is corrupted. Also gates the delayer on and off via an enable.

---
 rtl/signal_delay_pkg.sv | 16 +
 rtl/signal_delayer.sv | 30 +++
 rtl/signal_delay_ctrl.sv | 140 ++++++++++++++
 tb/tb_signal_delay_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/signal_delay_pkg.sv
// Shared types and constants for the signal delay sequencer.
// Imported by the controller and its bench.
package signal_delay_pkg;

  localparam int DW_DEF = 4;
  localparam int DRAIN_MARGIN = 2;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    APPLY,
    SETTLE
  } state_e;

endpackage

// File: rtl/signal_delayer.sv
// Programmable delay line: sig_out is sig_in delayed by
// delay_value cycles (0 = combinational pass-through).
module signal_delayer #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          sig_in,
  input  logic [DW-1:0] delay_value,
  output logic          sig_out
);

  localparam int N = 1 << DW;

  logic [N-2:0] sr_q;
  logic [N-1:0] tap;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_q <= '0;
    end else begin
      sr_q <= {sr_q[N-3:0], sig_in};
    end
  end

  // tap[k] is sig_in as it was k cycles ago
  assign tap = {sr_q, sig_in};
  assign sig_out = tap[delay_value];

endmodule

// File: rtl/signal_delay_ctrl.sv
// Sequencer owning signal_delayer's inputs: drains the line
// before a delay change, then applies it and settles.
module signal_delay_ctrl
  import signal_delay_pkg::*;
#(
  parameter int            DW         = DW_DEF,
  parameter logic [DW-1:0] RST_DELAY  = '0,
  parameter int            SETTLE_CYC = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic          sig_in,
  input  logic          cfg_valid,
  input  logic [DW-1:0] cfg_delay,
  output logic          cfg_ready,
  output logic          dly_sig_in,
  output logic [DW-1:0] dly_delay_value,
  output logic          cfg_done,
  output logic          busy,
  output logic          gated
);

  localparam logic [DW:0] DONE_D = (DW+1)'(1);
  localparam logic [DW:0] MARGIN = (DW+1)'(DRAIN_MARGIN);
  localparam logic [3:0]  SET_N  = 4'(SETTLE_CYC);
  localparam logic [3:0]  DONE_S = 4'd1;

  state_e        state_q, state_d;
  logic [DW-1:0] pend_q, pend_d;
  logic          pv_q, pv_d;
  logic [DW:0]   dcnt_q, dcnt_d;
  logic [3:0]    scnt_q, scnt_d;
  logic [DW-1:0] dly_q, dly_d;
  logic          done_q, done_d;
  logic          ready_q, dsi_q;
  logic          busy_q, gated_q;
  logic          hs, busy_d;
  logic [DW:0]   drain_n;

  assign hs = cfg_valid & ready_q;
  assign drain_n = {1'b0, dly_q} + MARGIN;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    pv_d    = pv_q;
    dcnt_d  = dcnt_q;
    scnt_d  = scnt_q;
    dly_d   = dly_q;
    done_d  = 1'b0;
    if (hs) pend_d = cfg_delay;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = APPLY;
          pv_d    = 1'b1;
        end else if (en) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (hs && cfg_delay == dly_q) begin
          done_d = 1'b1;
        end else if (hs) begin
          state_d = DRAIN;
          pv_d    = 1'b1;
          dcnt_d  = drain_n;
        end else if (!en) begin
          state_d = DRAIN;
          pv_d    = 1'b0;
          dcnt_d  = drain_n;
        end
      end
      DRAIN: begin
        if (dcnt_q <= DONE_D) begin
          state_d = pv_q ? APPLY : IDLE;
        end else begin
          dcnt_d = dcnt_q - DONE_D;
        end
      end
      APPLY: begin
        state_d = SETTLE;
        dly_d   = pend_q;
        done_d  = 1'b1;
        pv_d    = 1'b0;
        scnt_d  = SET_N;
      end
      SETTLE: begin
        if (scnt_q <= DONE_S) begin
          state_d = en ? RUN : IDLE;
        end else begin
          scnt_d = scnt_q - DONE_S;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs are registered from the next state
  assign busy_d = (state_d == DRAIN) ||
                  (state_d == APPLY) ||
                  (state_d == SETTLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      pend_q  <= '0;
      pv_q    <= 1'b0;
      dcnt_q  <= '0;
      scnt_q  <= '0;
      dly_q   <= RST_DELAY;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      dsi_q   <= 1'b0;
      busy_q  <= 1'b0;
      gated_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      pv_q    <= pv_d;
      dcnt_q  <= dcnt_d;
      scnt_q  <= scnt_d;
      dly_q   <= dly_d;
      done_q  <= done_d;
      ready_q <= !busy_d;
      dsi_q   <= (state_d == RUN) & sig_in;
      busy_q  <= busy_d;
      gated_q <= busy_d & en;
    end
  end

  assign cfg_ready       = ready_q;
  assign dly_sig_in      = dsi_q;
  assign dly_delay_value = dly_q;
  assign cfg_done        = done_q;
  assign busy            = busy_q;
  assign gated           = gated_q;

endmodule

// File: tb/tb_signal_delay_ctrl.sv
// Bench for signal_delay_ctrl driving a signal_delayer,
// checked against a timeline model of the sequencer.
module tb_signal_delay_ctrl;

  localparam int W = 4;
  localparam int S = 2;

  typedef enum {M_IDLE, M_RUN, M_SEQ} mmode_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic en = 1'b0;
  logic sig_in = 1'b0;
  logic cfg_valid = 1'b0;
  logic [W-1:0] cfg_delay = '0;
  logic cfg_ready, dly_sig_in, cfg_done;
  logic busy, gated, sig_out;
  logic [W-1:0] dly_delay_value;

  int n_cmp = 0;
  int n_bad = 0;

  mmode_t mode;
  int k, apply_at, exit_at, cur, pend;
  bit by_en, m_rdy, m_done, m_gated;
  bit past [16];

  always #5 clk = ~clk;

  signal_delay_ctrl #(
    .DW(W),
    .RST_DELAY(4'd0),
    .SETTLE_CYC(S)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .en(en),
    .sig_in(sig_in),
    .cfg_valid(cfg_valid),
    .cfg_delay(cfg_delay),
    .cfg_ready(cfg_ready),
    .dly_sig_in(dly_sig_in),
    .dly_delay_value(dly_delay_value),
    .cfg_done(cfg_done),
    .busy(busy),
    .gated(gated)
  );

  signal_delayer #(.DW(W)) u_dly (
    .clk(clk),
    .rstn(rstn),
    .sig_in(dly_sig_in),
    .delay_value(dly_delay_value),
    .sig_out(sig_out)
  );

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mode = M_IDLE;
    k = 0;
    cur = 0;
    pend = 0;
    apply_at = -1;
    exit_at = -1;
    by_en = 1'b0;
    m_rdy = 1'b0;
    m_done = 1'b0;
    m_gated = 1'b0;
    foreach (past[j]) past[j] = 1'b0;
  endtask

  // Timeline view: a reconfiguration is a blocked window
  // whose apply/exit edges are fixed when it is accepted.
  task automatic model_edge();
    bit hs;
    hs = cfg_valid && m_rdy;
    m_done = 1'b0;
    k++;
    case (mode)
      M_IDLE: begin
        if (hs) begin
          mode = M_SEQ;
          pend = int'(cfg_delay);
          apply_at = k + 1;
          exit_at = k + 1 + S;
          by_en = 1'b1;
        end else if (en) begin
          mode = M_RUN;
        end
      end
      M_RUN: begin
        if (hs && int'(cfg_delay) == cur) begin
          m_done = 1'b1;
        end else if (hs) begin
          mode = M_SEQ;
          pend = int'(cfg_delay);
          apply_at = k + cur + 3;
          exit_at = apply_at + S;
          by_en = 1'b1;
        end else if (!en) begin
          mode = M_SEQ;
          apply_at = -1;
          exit_at = k + cur + 2;
          by_en = 1'b0;
        end
      end
      default: begin
        if (k == apply_at) begin
          cur = pend;
          m_done = 1'b1;
        end else if (k == exit_at) begin
          mode = (by_en && en) ? M_RUN : M_IDLE;
        end
      end
    endcase
    m_rdy = (mode != M_SEQ);
    m_gated = (mode == M_SEQ) && en;
    for (int j = 15; j > 0; j--) past[j] = past[j-1];
    past[0] = (mode == M_RUN) && sig_in;
  endtask

  task automatic check_all();
    chk("busy", 8'(busy), 8'(mode == M_SEQ));
    chk("cfg_ready", 8'(cfg_ready), 8'(m_rdy));
    chk("dly_sig_in", 8'(dly_sig_in), 8'(past[0]));
    chk("gated", 8'(gated), 8'(m_gated));
    chk("cfg_done", 8'(cfg_done), 8'(m_done));
    chk("delay", 8'(dly_delay_value), 8'(cur));
    chk("sig_out", 8'(sig_out), 8'(past[cur]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int nb, ng;
    #2;
    model_reset();
    check_all();
    #10 rstn = 1'b1;

    // 1: pass-through at delay 0
    en = 1'b1;
    sig_in = 1'b1;
    repeat (3) step();
    sig_in = 1'b0;
    repeat (2) step();
    chk("t1_delay", 8'(dly_delay_value), 8'd0);
    chk("t1_ready", 8'(cfg_ready), 8'd1);

    // 2: change to 7 from delay 0
    cfg_valid = 1'b1;
    cfg_delay = 4'd7;
    step();
    cfg_valid = 1'b0;
    nb = int'(busy);
    for (int i = 0; i < 20; i++) begin
      sig_in = 1'($urandom);
      step();
      nb += int'(busy);
    end
    chk("t2_busy_cycles", 8'(nb), 8'd5);
    chk("t2_delay", 8'(dly_delay_value), 8'd7);

    // 3: same delay again, no drain
    sig_in = 1'b1;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    nb = int'(busy);
    repeat (3) begin
      step();
      nb += int'(busy);
    end
    chk("t3_busy_cycles", 8'(nb), 8'd0);

    // 4: go to 15, then 3 with a long drain
    cfg_valid = 1'b1;
    cfg_delay = 4'd15;
    step();
    cfg_valid = 1'b0;
    repeat (25) step();
    chk("t4_pre_delay", 8'(dly_delay_value), 8'd15);
    sig_in = 1'b1;
    cfg_valid = 1'b1;
    cfg_delay = 4'd3;
    nb = 0;
    ng = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      nb += int'(busy);
      ng += int'(gated);
      if (i == 0) cfg_delay = 4'd9;
      if (i == 14) cfg_valid = 1'b0;
    end
    chk("t4_busy_cycles", 8'(nb), 8'd20);
    chk("t4_gated_cycles", 8'(ng), 8'd20);
    chk("t4_delay", 8'(dly_delay_value), 8'd3);

    // 5: en falls together with a handshake
    en = 1'b0;
    cfg_valid = 1'b1;
    cfg_delay = 4'd5;
    step();
    cfg_valid = 1'b0;
    repeat (12) step();
    chk("t5_delay", 8'(dly_delay_value), 8'd5);
    chk("t5_busy", 8'(busy), 8'd0);
    chk("t5_dsi", 8'(dly_sig_in), 8'd0);

    // 6: reset in the middle of a drain
    en = 1'b1;
    repeat (2) step();
    cfg_valid = 1'b1;
    cfg_delay = 4'd9;
    step();
    cfg_valid = 1'b0;
    repeat (2) step();
    chk("t6_busy_pre", 8'(busy), 8'd1);
    #1;
    rstn = 1'b0;
    en = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("t6_delay", 8'(dly_delay_value), 8'd0);
    #2 rstn = 1'b1;
    repeat (4) step();
    chk("t6_ready", 8'(cfg_ready), 8'd1);

    // random traffic against the timeline model
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 9) != 0);
      sig_in = 1'($urandom);
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_delay = 4'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
